// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames and folds the E0/F0
// prefixes into key_ext/key_make attributes on the following scan code.
module ps2_keyboard_rx #(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       rx_err
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_prev_q;
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [25:0] wd_cnt_q, wd_cnt_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [7:0]  keycode_d;
  logic        key_make_d, key_ext_d, key_valid_d, rx_err_d;

  logic fall, sample, timeout;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign sample  = dat_sync_q[1];
  // A fall in the same cycle proves the keyboard is still clocking, so it wins.
  assign timeout = (state_q != StIdle) && !fall && (wd_cnt_q == TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode;
    key_make_d  = key_make;
    key_ext_d   = key_ext;
    key_valid_d = 1'b0;
    rx_err_d    = 1'b0;
    wd_cnt_d    = (state_q == StIdle || fall) ? 26'd0 : wd_cnt_q + 26'd1;

    if (timeout) begin
      state_d  = StIdle;
      rx_err_d = 1'b1;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      wd_cnt_d = 26'd0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!sample) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = sample;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (sample && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              keycode_d   = shift_q;
              key_make_d  = ~brk_q;
              key_ext_d   = ext_q;
              key_valid_d = 1'b1;
              ext_d       = 1'b0;
              brk_d       = 1'b0;
            end
          end else begin
            rx_err_d = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Idle level, so releasing reset cannot fake a falling edge.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      wd_cnt_q   <= 26'd0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      keycode    <= 8'h00;
      key_make   <= 1'b0;
      key_ext    <= 1'b0;
      key_valid  <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wd_cnt_q   <= wd_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      keycode    <= keycode_d;
      key_make   <= key_make_d;
      key_ext    <= key_ext_d;
      key_valid  <= key_valid_d;
      rx_err     <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: a prefix-folding model queues expected events and a
// negedge monitor pops and compares each key_valid/rx_err pulse.
module tb_ps2_keyboard_rx;

  localparam logic [25:0] Timeout = 26'd100;
  localparam int Half = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] keycode;
  logic       key_make, key_ext, key_valid, rx_err;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .keycode  (keycode),
    .key_make (key_make),
    .key_ext  (key_ext),
    .key_valid(key_valid),
    .rx_err   (rx_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       make;
    logic       ext;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Model state: pending prefix attributes.
  bit m_ext = 0;
  bit m_brk = 0;

  // Returns 0 = no pulse, 1 = key_valid, 2 = rx_err.
  function automatic int model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      e = '{is_err: 1'b1, code: 8'h00, make: 1'b0, ext: 1'b0};
      sb.push_back(e);
      m_ext = 0;
      m_brk = 0;
      return 2;
    end
    if (b == 8'hE0) begin
      m_ext = 1;
      return 0;
    end
    if (b == 8'hF0) begin
      m_brk = 1;
      return 0;
    end
    e = '{is_err: 1'b0, code: b, make: !m_brk, ext: m_ext};
    sb.push_back(e);
    m_ext = 0;
    m_brk = 0;
    return 1;
  endfunction

  // Monitor: every pulse is matched against the queue head; outputs must hold otherwise.
  logic [9:0] prev_out = '0;
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      prev_out = '0;
    end else begin
      if (key_valid && rx_err) begin
        n_bad++;
        $display("FAIL both_pulses: key_valid=%0b rx_err=%0b, required not both", key_valid,
                 rx_err);
      end
      if (key_valid || rx_err) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: key_valid=%0b rx_err=%0b code=%02h, required none",
                   key_valid, rx_err, keycode);
        end else begin
          e = sb.pop_front();
          if (e.is_err && !(rx_err && !key_valid)) begin
            n_bad++;
            $display("FAIL err_event: key_valid=%0b rx_err=%0b, required rx_err", key_valid,
                     rx_err);
          end else if (!e.is_err && (!key_valid || keycode != e.code || key_make != e.make ||
                                     key_ext != e.ext)) begin
            n_bad++;
            $display("FAIL key_event: valid=%0b code=%02h make=%0b ext=%0b, required code=%02h make=%0b ext=%0b",
                     key_valid, keycode, key_make, key_ext, e.code, e.make, e.ext);
          end
        end
      end else begin
        n_cmp++;
        if ({keycode, key_make, key_ext} != prev_out) begin
          n_bad++;
          $display("FAIL hold: outputs=%03h, required %03h", {keycode, key_make, key_ext},
                   prev_out);
        end
      end
      if (key_valid) prev_out = {keycode, key_make, key_ext};
    end
  end

  // One PS/2 bit; with kind >= 0 also checks the pulse lands exactly on the third clk edge.
  task automatic ps2_bit(input logic b, input int kind);
    ps2_dat = b;
    repeat (Half) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (kind >= 0) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (key_valid || rx_err) begin
        n_bad++;
        $display("FAIL early_pulse: key_valid=%0b rx_err=%0b, required 0 before 3rd edge",
                 key_valid, rx_err);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (key_valid != (kind == 1) || rx_err != (kind == 2)) begin
        n_bad++;
        $display("FAIL latency: key_valid=%0b rx_err=%0b, required kind %0d on 3rd edge",
                 key_valid, rx_err, kind);
      end
      repeat (Half - 3) @(posedge clk);
    end else begin
      repeat (Half) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic idle(input int n);
    ps2_dat = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int kind;
    logic par;
    par  = ~(^b) ^ bad_par;
    kind = model_byte(b, !bad_par && !bad_stop);
    ps2_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], -1);
    ps2_bit(par, -1);
    ps2_bit(!bad_stop, kind);
    idle(2 * Half);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, -1);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], -1);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    n_cmp++;
    if (keycode != 8'h00 || key_make || key_ext || key_valid || rx_err) begin
      n_bad++;
      $display("FAIL %s: code=%02h make=%0b ext=%0b valid=%0b err=%0b, required all 0", tag,
               keycode, key_make, key_ext, key_valid, rx_err);
    end
  endtask

  initial begin
    logic [7:0] b;
    int r;
    repeat (3) @(posedge clk);
    check_zero_outputs("reset_state");
    #1 reset = 1'b0;
    idle(10);

    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h74, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h75, 1, 0);
    send_frame(8'h72, 0, 0);

    // Watchdog: prefix, then a stalled partial frame.
    send_frame(8'hE0, 0, 0);
    send_partial(8'h6B, 3);
    void'(model_byte(8'h00, 0));
    idle(int'(Timeout) + 5);
    send_frame(8'h6B, 0, 0);

    // Prefix then stop-bit error must not leak the break attribute.
    send_frame(8'hF0, 0, 0);
    send_frame(8'h33, 0, 1);
    send_frame(8'h33, 0, 0);

    // Reset mid-frame.
    send_partial(8'h6B, 5);
    reset = 1'b1;
    m_ext = 0;
    m_brk = 0;
    @(posedge clk);
    check_zero_outputs("mid_frame_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    idle(10);
    send_frame(8'h1C, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else begin
        b = 8'($urandom_range(0, 255));
        while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
      end
      r = int'($urandom_range(0, 11));
      send_frame(b, r == 0, r == 1);
    end

    idle(20);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d events outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 26'd50_000, is the maximum number of clk cycles allowed between ps2_clk falling edges inside one frame (1 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  keyboard clock pin; asynchronous to clk; idles high.
REQ-005 ps2_dat  input  1  keyboard data pin; asynchronous to clk; idles high.
REQ-006 keycode  output  8  last completed scan code, excluding prefix bytes; held between events.
REQ-007 key_make  output  1  1 = press (make), 0 = release (break) for the current keycode; held between events.
REQ-008 key_ext  output  1  1 = keycode was preceded by E0; held between events.
REQ-009 key_valid  output  1  one-cycle pulse when keycode, key_make and key_ext update.
REQ-010 rx_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 ps2_clk and ps2_dat SHALL each pass through a two-flop synchronizer; a falling edge SHALL be detected from the synchronized ps2_clk and its one-cycle-delayed copy.
REQ-012 ps2_dat SHALL be sampled only in the cycle a falling edge is detected.
REQ-013 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: a sample of 0 (start bit) SHALL enter DATA with the bit count at 0; a sample of 1 SHALL be ignored with no state change.
REQ-015 DATA: each sample SHALL shift in LSB first; after the 8th sample, the FSM SHALL enter PARITY.
REQ-016 PARITY: the sample SHALL be stored and the FSM SHALL enter STOP; the parity check passes when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-017 STOP: a sample of 1 with a passing parity check completes a byte; any other combination SHALL pulse rx_err and discard the byte; in both cases the FSM SHALL return to IDLE.
REQ-018 A completed byte of 8'hE0 SHALL set the internal ext flag, produce no output update and no key_valid.
REQ-019 A completed byte of 8'hF0 SHALL set the internal break flag, produce no output update and no key_valid.
REQ-020 Prefix flags SHALL be sticky in either order until the next non-prefix byte; a repeated prefix SHALL leave its flag set.
REQ-021 A completed non-prefix byte SHALL load keycode with the byte, key_make with NOT break flag and key_ext with the ext flag, pulse key_valid, and clear both flags, all on the same clk edge.
REQ-022 Latency: key_valid SHALL be high during the cycle that follows the clk edge on which the stop-bit falling edge is detected, which is the third clk edge after the ps2_clk pin falls.
REQ-023 The watchdog counter SHALL clear on every detected falling edge and when the FSM is in IDLE, and SHALL increment in the other states.
REQ-024 When the watchdog counter reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE, pulse rx_err, and clear the prefix flags.
REQ-025 A parity or stop-bit error SHALL also clear the prefix flags, so that a corrupted sequence never yields a spurious ext or break attribute.
REQ-026 key_valid and rx_err SHALL never be asserted in the same cycle, and neither SHALL be asserted for more than one consecutive cycle.
REQ-027 keycode, key_make and key_ext SHALL change only on a key_valid cycle.

Reset
REQ-028 When reset is asserted, the following SHALL be cleared on the next clk edge: FSM to IDLE, bit count, shift register, watchdog counter and prefix flags.
REQ-029 On that same edge, keycode SHALL go to 8'h00 and key_make, key_ext, key_valid and rx_err SHALL go to 0.
REQ-030 Reset SHALL take priority over any simultaneous falling edge or timeout.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the next start bit after reset is released SHALL be received normally.
REQ-032 Synchronizer flops SHALL reset to 1 (the idle level), so that releasing reset never produces a false falling edge.

Verification
REQ-033 Frames 8'h1C -> one key_valid pulse; keycode = 8'h1C, key_make = 1, key_ext = 0.
REQ-034 Frames E0, 6B -> exactly one key_valid pulse; keycode = 8'h6B, key_make = 1, key_ext = 1; no pulse after the E0 frame.
REQ-035 Frames E0, F0, 74 followed by F0, 1C -> two pulses: (8'h74, make = 0, ext = 1) then (8'h1C, make = 0, ext = 0).
REQ-036 Frame 8'h75 with an even parity bit, then frame 8'h72 -> rx_err pulses once, outputs unchanged after the first frame; then key_valid pulses with keycode = 8'h72.
REQ-037 Frame E0, then start bit + 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES+5 cycles, then a full 8'h6B frame -> rx_err pulses once; then key_valid pulses with key_ext = 0 (ext flag cleared).
REQ-038 Reset asserted after 5 data bits of 8'h6B, then a full frame 8'h1C -> all outputs 0 during reset; then one key_valid pulse with keycode = 8'h1C.
